// File: rtl/aes_256_job_scheduler.sv
// Round-robin scheduler sharing one AES-256 core among NUM_REQ requesters.
// Optional RUN-state watchdog enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_256_job_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*256-1:0] req_key,
  input  logic [NUM_REQ*128-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [127:0]           resp_data,
  output logic                   resp_err,
  output logic                   core_rst_n,
  output logic                   core_en,
  output logic [255:0]           core_key,
  output logic [127:0]           core_din,
  input  logic                   core_done,
  input  logic [127:0]           core_dout
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < $clog2(NUM_REQ) ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_params
    $error("aes_256_job_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, LOAD, CLR, RUN, RESP} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            timeout;

`ifdef AES_SCHED_TIMEOUT_EN
  logic [15:0] run_cnt;

  always_ff @(posedge Clk) begin
    if (!Rst)              run_cnt <= '0;
    else if (state != RUN) run_cnt <= '0;
    else                   run_cnt <= run_cnt + 16'd1;
  end

  assign timeout = (state == RUN) && (32'(run_cnt) == TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif

  // Two passes: indices at or above rr_ptr first, then the wrapped-around ones.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[k] && k >= 32'(rr_ptr)) begin
        found  = 1'b1;
        winner = ID_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[k] && k < 32'(rr_ptr)) begin
        found  = 1'b1;
        winner = ID_W'(k);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = LOAD;
      LOAD:    state_next = CLR;
      CLR:     state_next = RUN;
      RUN:     if (core_done || timeout) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake/core controls are registered from state_next so they track the state exactly.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      req_ack    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      core_rst_n <= 1'b0;
      core_en    <= 1'b0;
      core_key   <= '0;
      core_din   <= '0;
    end else begin
      state      <= state_next;
      req_ack    <= '0;
      resp_valid <= (state_next == RESP);
      core_rst_n <= (state_next != CLR);
      core_en    <= (state_next == RUN);
      case (state)
        IDLE: begin
          if (found) begin
            core_key <= req_key[32'(winner)*256 +: 256];
            core_din <= req_data[32'(winner)*128 +: 128];
            resp_id  <= winner;
            resp_err <= 1'b0;
            rr_ptr   <= (32'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
            req_ack  <= NUM_REQ'(1) << winner;
          end
        end
        RUN: begin
          if (core_done) begin
            resp_data <= core_dout;
          end else if (timeout) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_256_job_scheduler.sv
// Bench for aes_256_job_scheduler: randomized jobs against a round-robin
// reference model, with a behavioural AES core stand-in.
module tb_aes_256_job_scheduler;

  localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         Clk, Rst;
  logic [3:0]   req;
  logic [1023:0] req_key;
  logic [511:0] req_data;
  logic [3:0]   req_ack;
  logic         resp_valid, resp_ready;
  logic [1:0]   resp_id;
  logic [127:0] resp_data;
  logic         resp_err;
  logic         core_rst_n, core_en;
  logic [255:0] core_key;
  logic [127:0] core_din;
  logic         core_done;
  logic [127:0] core_dout;

  int vectors = 0;
  int miscompares = 0;
  int m_ptr = 0;
  bit stub_on = 1'b1;
  bit stray = 1'b0;
  int stub_cnt = 0;
  int stub_lat = 1;
  bit stub_fired = 1'b0;

  aes_256_job_scheduler #(
    .NUM_REQ(4),
    .ID_W(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .req_key(req_key), .req_data(req_data),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .core_rst_n(core_rst_n), .core_en(core_en), .core_key(core_key),
    .core_din(core_din), .core_done(core_done), .core_dout(core_dout)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core stand-in: known-answer vector for the reference key/plaintext, a keyed mix otherwise.
  function automatic logic [127:0] core_f(input logic [255:0] k, input logic [127:0] d);
    if (k == KAT_KEY && d == KAT_PT) return KAT_CT;
    return d ^ k[127:0] ^ k[255:128] ^ 128'h5a5a_0f0f_c3c3_9696_a5a5_f0f0_3c3c_6969;
  endfunction

  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int i = 0; i < 4; i++) begin
      if (m[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  initial begin
    core_done = 1'b0;
    core_dout = '0;
    forever begin
      @(negedge Clk);
      core_done = 1'b0;
      if (!core_rst_n) begin
        stub_cnt   = 0;
        stub_fired = 1'b0;
        stub_lat   = $urandom_range(1, 8);
      end else if (core_en && !stub_fired && stub_on) begin
        stub_cnt++;
        if (stub_cnt == stub_lat) begin
          core_done  = 1'b1;
          core_dout  = core_f(core_key, core_din);
          stub_fired = 1'b1;
        end
      end
      if (stray) core_done = 1'b1;
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic randomize_slots();
    for (int j = 0; j < 32; j++) req_key[j*32 +: 32] = $urandom;
    for (int j = 0; j < 16; j++) req_data[j*32 +: 32] = $urandom;
  endtask

  task automatic do_job(input int bp, input logic [3:0] new_req, input bit tmo, output int w);
    int exp_w, n, runc;
    logic [255:0] ek;
    logic [127:0] ed, er;
    bit prev_done;
    exp_w = rr_pick(req, m_ptr);
    w = -1;
    n = 0;
    while (req_ack == 4'b0 && n < 50) begin
      tick();
      n++;
    end
    check("ack", req_ack, 1 << exp_w);
    if (req_ack == 4'b0) return;
    check("ack_latency", n, 1);
    w = exp_w;
    m_ptr = (exp_w + 1) % 4;
    ek = req_key[exp_w*256 +: 256];
    ed = req_data[exp_w*128 +: 128];
    er = tmo ? 128'b0 : core_f(ek, ed);
    req = new_req;
    for (int j = 0; j < 8; j++) req_key[exp_w*256 + j*32 +: 32] = $urandom;
    for (int j = 0; j < 4; j++) req_data[exp_w*128 + j*32 +: 32] = $urandom;
    tick();
    check("clr_rst_n", core_rst_n, 0);
    check("clr_en", core_en, 0);
    check("clr_ack", req_ack, 0);
    tick();
    check("run_en", core_en, 1);
    check("run_rst_n", core_rst_n, 1);
    check("core_key", core_key, ek);
    check("core_din", core_din, ed);
    runc = 1;
    prev_done = 1'b0;
    n = 0;
    while (!resp_valid && n < 300) begin
      prev_done = core_done;
      tick();
      if (core_en) runc++;
      n++;
    end
    check("resp_valid", resp_valid, 1);
    if (!resp_valid) return;
    if (tmo) check("tmo_run_cycles", runc, 16);
    else     check("done_to_valid", prev_done, 1);
    check("resp_en_drop", core_en, 0);
    check("resp_id", resp_id, exp_w);
    check("resp_data", resp_data, er);
    check("resp_err", resp_err, tmo);
    for (int i = 0; i < bp; i++) begin
      tick();
      check("hold", {req_ack, resp_valid, resp_id, resp_err, resp_data},
            {4'b0, 1'b1, 2'(exp_w), tmo, er});
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1);
  end

  initial begin
    int w, n;
    Rst = 1'b0;
    req = 4'hF;
    resp_ready = 1'b0;
    randomize_slots();

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ctl", {req_ack, resp_valid, resp_id, resp_err, core_rst_n, core_en}, 0);
      check("rst_data", resp_data, 0);
      check("rst_key", core_key, 0);
      check("rst_din", core_din, 0);
    end

    req_key[2*256 +: 256] = KAT_KEY;
    req_data[2*128 +: 128] = KAT_PT;
    req = 4'b0100;
    Rst = 1'b1;
    m_ptr = 0;
    do_job(0, 4'b0000, 1'b0, w);
    check("kat_id", w, 2);

    stray = 1'b1;
    tick();
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stray_done", {req_ack, resp_valid, core_en}, 0);
    end

    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    m_ptr = 0;
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      do_job(0, 4'hF, 1'b0, w);
      check("fair_order", w, i % 4);
    end

    do_job(10, 4'hF, 1'b0, w);

    stub_on = 1'b0;
    n = 0;
    while (req_ack == 4'b0 && n < 50) begin
      tick();
      n++;
    end
    check("abort_ack", req_ack, 1 << rr_pick(req, m_ptr));
    req = 4'b0;
    tick();
    tick();
    check("abort_run", core_en, 1);
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    m_ptr = 0;
    stub_on = 1'b1;
    check("abort_rst", {core_en, core_rst_n, resp_valid, req_ack}, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_quiet", {resp_valid, req_ack, core_en}, 0);
    end
    randomize_slots();
    req = 4'b0010;
    do_job(1, 4'b1001, 1'b0, w);
    check("abort_next", w, 1);

`ifdef AES_SCHED_TIMEOUT_EN
    stub_on = 1'b0;
    do_job(2, 4'b0100, 1'b1, w);
    stub_on = 1'b1;
`endif

    for (int it = 0; it < 30; it++) begin
      randomize_slots();
      do_job($urandom_range(0, 3), 4'($urandom_range(1, 15)), 1'b0, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
